nor_threshold_seq: RTL and testbench

//  Sequential, parametrised successor of the flat NOR/INV threshold-logic blocks.

---
 rtl/nor_threshold_seq_if.sv | 27 ++
 rtl/nor_threshold_seq.sv | 116 +++++++++++
 tb/tb_nor_threshold_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nor_threshold_seq_if.sv
// Operand/result channel of nor_threshold_seq: valid/ready operand input and
// valid/ready result output, sized by channel count N and field width W.
interface nor_threshold_seq_if #(
  parameter int N = 5,
  parameter int W = $clog2(N + 1)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         in_force;
  logic [W-1:0] in_thr;
  logic         out_valid;
  logic         out_ready;
  logic         out_f;
  logic [W-1:0] out_count;
  logic [W-1:0] out_scanned;

  modport master (
    output in_valid, in_vec, in_force, in_thr, out_ready,
    input  in_ready, out_valid, out_f, out_count, out_scanned
  );

  modport slave (
    input  in_valid, in_vec, in_force, in_thr, out_ready,
    output in_ready, out_valid, out_f, out_count, out_scanned
  );
endinterface

// File: rtl/nor_threshold_seq.sv
// Bit-serial threshold evaluator: f = force | (popcount(vec) >= thr), one input
// bit scanned per clock, LSB first, with optional early exit once f is decided.
module nor_threshold_seq #(
  parameter int N          = 5,
  parameter int W          = $clog2(N + 1),
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  nor_threshold_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [W:0] LAST   = (W+1)'(N - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [W-1:0] thr_q, thr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         f_q, f_d;
  logic [W-1:0] ocnt_q, ocnt_d;
  logic [W-1:0] oscn_q, oscn_d;

  logic         bit_cur;
  logic [W-1:0] cnt_next, idx_next;
  logic [W:0]   reach;
  logic         hit, miss, finish;

  always_comb begin
    bit_cur = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == W'(i)) bit_cur = vec_q[i];
    end
  end

  // reach = best count still attainable once the current bit is counted
  assign cnt_next = cnt_q + W'(bit_cur);
  assign idx_next = idx_q + W'(1);
  assign reach    = {1'b0, cnt_next} + (LAST - {1'b0, idx_q});
  assign hit      = (cnt_next >= thr_q);
  assign miss     = (reach < {1'b0, thr_q});
  assign finish   = ({1'b0, idx_q} == LAST) || (EARLY_EXIT && (hit || miss));

  assign bus.in_ready    = (state_q == S_IDLE) && !rst;
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out_f       = f_q;
  assign bus.out_count   = ocnt_q;
  assign bus.out_scanned = oscn_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    thr_d   = thr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    ocnt_d  = ocnt_q;
    oscn_d  = oscn_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          vec_d = bus.in_vec;
          thr_d = bus.in_thr;
          idx_d = '0;
          cnt_d = '0;
          if (bus.in_force || (bus.in_thr == '0)) begin
            state_d = S_DONE;
            f_d     = 1'b1;
            ocnt_d  = '0;
            oscn_d  = '0;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        cnt_d = cnt_next;
        idx_d = idx_next;
        if (finish) begin
          state_d = S_DONE;
          f_d     = hit;
          ocnt_d  = cnt_next;
          oscn_d  = idx_next;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      thr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      f_q     <= 1'b0;
      ocnt_q  <= '0;
      oscn_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      thr_q   <= thr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      ocnt_q  <= ocnt_d;
      oscn_q  <= oscn_d;
    end
  end
endmodule

// File: tb/tb_nor_threshold_seq.sv
// Bench: one full-scan and one early-exit instance share stimulus; each result is
// checked against a popcount/prefix model, including latency and DONE hold behaviour.
module tb_nor_threshold_seq;
  localparam int N = 5;
  localparam int W = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_force = 1'b0;
  logic [N-1:0] in_vec   = '0;
  logic [W-1:0] in_thr   = '0;
  logic         ordy [2];
  logic         ov [2];
  logic         ir [2];
  logic         of [2];
  logic [W-1:0] oc [2];
  logic [W-1:0] os [2];

  int tests_run    = 0;
  int tests_failed = 0;

  nor_threshold_seq_if #(.N(N), .W(W)) ifa ();
  nor_threshold_seq_if #(.N(N), .W(W)) ifb ();

  nor_threshold_seq #(.N(N), .W(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifa));
  nor_threshold_seq #(.N(N), .W(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.in_valid  = in_valid;
  assign ifa.in_force  = in_force;
  assign ifa.in_vec    = in_vec;
  assign ifa.in_thr    = in_thr;
  assign ifa.out_ready = ordy[0];
  assign ifb.in_valid  = in_valid;
  assign ifb.in_force  = in_force;
  assign ifb.in_vec    = in_vec;
  assign ifb.in_thr    = in_thr;
  assign ifb.out_ready = ordy[1];

  assign ov[0] = ifa.out_valid;  assign ov[1] = ifb.out_valid;
  assign ir[0] = ifa.in_ready;   assign ir[1] = ifb.in_ready;
  assign of[0] = ifa.out_f;      assign of[1] = ifb.out_f;
  assign oc[0] = ifa.out_count;  assign oc[1] = ifb.out_count;
  assign os[0] = ifa.out_scanned; assign os[1] = ifb.out_scanned;

  // Expected result; scn doubles as the number of edges after the accept edge
  // before out_valid is seen (0 for the no-scan force/thr==0 path).
  function automatic void model(input logic [N-1:0] vec, input int unsigned thr,
                                input bit frc, input bit ee,
                                output bit f, output int cnt, output int scn);
    int pc;
    logic [N-1:0] m;
    pc = $countones(vec);
    if (frc || thr == 0) begin
      f = 1'b1; cnt = 0; scn = 0;
      return;
    end
    f = (pc >= int'(thr));
    cnt = pc; scn = N;
    if (!ee) return;
    for (int k = 1; k <= N; k++) begin
      int pre;
      m   = N'((1 << k) - 1);
      pre = $countones(vec & m);
      if (pre >= int'(thr) || pre + (N - k) < int'(thr)) begin
        cnt = pre; scn = k;
        return;
      end
    end
  endfunction

  task automatic run_op(input logic [N-1:0] vec, input int unsigned thr, input bit frc,
                        input int unsigned hold, input string tag);
    bit ef [2];
    int ec [2];
    int es [2];
    int unsigned phase [2];
    int unsigned hcnt [2];
    int unsigned cyc, guard;
    model(vec, thr, frc, 1'b0, ef[0], ec[0], es[0]);
    model(vec, thr, frc, 1'b1, ef[1], ec[1], es[1]);
    guard = 0;
    while (!(ir[0] && ir[1]) && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    tests_run++;
    if (!(ir[0] && ir[1])) begin
      tests_failed++;
      $display("FAIL %s ready_wait: in_ready=%b%b required 11", tag, ir[1], ir[0]);
    end
    in_vec = vec; in_thr = W'(thr); in_force = frc; in_valid = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ordy[d] = (hold == 0); phase[d] = 0; hcnt[d] = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_vec = N'($urandom); in_thr = W'($urandom); in_force = 1'($urandom);
    cyc = 0;
    while ((phase[0] != 3 || phase[1] != 3) && cyc < 40) begin
      for (int d = 0; d < 2; d++) begin
        case (phase[d])
          0: if (ov[d]) begin
            tests_run++;
            if (cyc !== es[d]) begin
              tests_failed++;
              $display("FAIL %s dut%0d latency: got %0d required %0d", tag, d, cyc, es[d]);
            end
            tests_run++;
            if (of[d] !== ef[d]) begin
              tests_failed++;
              $display("FAIL %s dut%0d out_f: got %b required %b", tag, d, of[d], ef[d]);
            end
            tests_run++;
            if (oc[d] !== W'(ec[d])) begin
              tests_failed++;
              $display("FAIL %s dut%0d out_count: got %0d required %0d", tag, d, oc[d], ec[d]);
            end
            tests_run++;
            if (os[d] !== W'(es[d])) begin
              tests_failed++;
              $display("FAIL %s dut%0d out_scanned: got %0d required %0d", tag, d, os[d], es[d]);
            end
            tests_run++;
            if (ir[d] !== 1'b0) begin
              tests_failed++;
              $display("FAIL %s dut%0d in_ready_done: got %b required 0", tag, d, ir[d]);
            end
            phase[d] = (hold == 0) ? 2 : 1;
          end
          1: begin
            tests_run++;
            if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || of[d] !== ef[d] ||
                oc[d] !== W'(ec[d]) || os[d] !== W'(es[d])) begin
              tests_failed++;
              $display("FAIL %s dut%0d hold: got v=%b r=%b f=%b c=%0d s=%0d required v=1 r=0 f=%b c=%0d s=%0d",
                       tag, d, ov[d], ir[d], of[d], oc[d], os[d], ef[d], ec[d], es[d]);
            end
            hcnt[d]++;
            if (hcnt[d] >= hold) begin
              ordy[d] = 1'b1; phase[d] = 2;
            end
          end
          2: begin
            tests_run++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
              tests_failed++;
              $display("FAIL %s dut%0d after_handshake: got v=%b r=%b required v=0 r=1", tag, d, ov[d], ir[d]);
            end
            ordy[d] = 1'b0; phase[d] = 3;
          end
          default: ;
        endcase
      end
      if (phase[0] != 3 || phase[1] != 3) begin
        @(posedge clk); #1; cyc++;
      end
    end
    tests_run++;
    if (phase[0] != 3 || phase[1] != 3) begin
      tests_failed++;
      $display("FAIL %s timeout: phases %0d/%0d required 3/3", tag, phase[0], phase[1]);
      ordy[0] = 1'b0; ordy[1] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; ordy[0] = 1'b0; ordy[1] = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ir[0] !== 1'b0 || ir[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset in_ready_during: got %b%b required 00", ir[1], ir[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || of[d] !== 1'b0 || oc[d] !== '0 || os[d] !== '0) begin
        tests_failed++;
        $display("FAIL reset dut%0d state: got r=%b v=%b f=%b c=%0d s=%0d required r=1 v=0 f=0 c=0 s=0",
                 d, ir[d], ov[d], of[d], oc[d], os[d]);
      end
    end
  endtask

  task automatic test_directed();
    run_op(5'b10011, 3, 1'b0, 0, "T1");
    run_op(5'b00001, 3, 1'b0, 0, "T2");
    run_op(5'b00000, 5, 1'b1, 0, "T3");
    run_op(5'b00111, 3, 1'b0, 0, "T4a");
    run_op(5'b11000, 3, 1'b0, 0, "T4b");
    run_op(5'b11111, 0, 1'b0, 0, "thr0");
    run_op(5'b11111, 7, 1'b0, 0, "thr_gt_n");
    run_op(5'b11111, 5, 1'b0, 0, "all_ones");
  endtask

  task automatic test_hold();
    run_op(5'b10011, 3, 1'b0, 4, "T5");
  endtask

  task automatic test_reset_mid_scan();
    in_vec = 5'b10101; in_thr = W'(3); in_force = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL T6 scanning: out_valid=%b%b required 00", ov[1], ov[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ir[0] !== 1'b0 || ir[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL T6 in_reset: got v=%b%b r=%b%b required v=00 r=00", ov[1], ov[0], ir[1], ir[0]);
    end
    rst = 1'b0; #1;
    tests_run++;
    if (ir[0] !== 1'b1 || ir[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL T6 idle_after: in_ready=%b%b required 11", ir[1], ir[0]);
    end
    run_op(5'b10011, 3, 1'b0, 0, "T6_new");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(N'($urandom), $urandom_range(0, 7), ($urandom_range(0, 7) == 0),
             $urandom_range(0, 2), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
